// File: rtl/cordic_sched_pkg.sv
// ----------------------------------------------------------------------------
// cordic_sched_pkg : widths and config-select codes for the CORDIC scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cordic_sched_pkg;

  localparam int FCW_W  = 36;
  localparam int PH_W   = 22;
  localparam int OUT_W  = 16;
  localparam int PH_LSB = 14;

  typedef enum logic [1:0] {
    CFG_FCW  = 2'd0,
    CFG_EN   = 2'd1,
    CFG_OFS  = 2'd2,
    CFG_NONE = 2'd3
  } cfg_sel_e;

endpackage

`default_nettype wire

// File: rtl/cordic_rr_arb.sv
// ----------------------------------------------------------------------------
// cordic_rr_arb : round-robin arbiter, first requester after the last grant
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cordic_rr_arb #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx,
  output logic            vld
);

  logic [CH_W-1:0] cand;

  // Scan offsets 1..NCH so the last grantee has the lowest priority.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CH_W'((int'(last) + k) % NCH);
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_chan_sched.sv
// ----------------------------------------------------------------------------
// cordic_chan_sched : shares one CORDIC core among NCH NCO channels, round-robin
// Optional CORDIC_SCHED_POFS_EN adds a per-channel phase offset. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cordic_chan_sched
  import cordic_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = 2,
  parameter int LAT  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [FCW_W-1:0] cfg_wdata,
  output logic [PH_W-1:0]  core_phase,
  output logic             core_vld,
  input  logic [OUT_W-1:0] core_sin,
  input  logic [OUT_W-1:0] core_cos,
  output logic             res_vld,
  output logic [CH_W-1:0]  res_ch,
  output logic [OUT_W-1:0] res_sin,
  output logic [OUT_W-1:0] res_cos
);

  logic [FCW_W-1:0] fcw [NCH];
  logic [FCW_W-1:0] acc [NCH];
  logic [NCH-1:0]   en;
  logic [CH_W-1:0]  last;
  logic [NCH-1:0]   gnt;
  logic [CH_W-1:0]  gidx;
  logic             gvld;
  logic [PH_W-1:0]  phase;
  logic             ch_ok;
  logic [LAT-1:0]   tv;
  logic [CH_W-1:0]  tc [LAT];
  logic             cap;

  assign ch_ok = ({1'b0, cfg_ch} < (CH_W+1)'(NCH));

  cordic_rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req  (en),
    .last (last),
    .gnt  (gnt),
    .idx  (gidx),
    .vld  (gvld)
  );

`ifdef CORDIC_SCHED_POFS_EN
  logic [PH_W-1:0] ofs [NCH];

  assign phase = acc[gidx][FCW_W-1:PH_LSB] + ofs[gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ofs[i] <= '0;
    end else if (cfg_we && ch_ok && cfg_sel == CFG_OFS) begin
      ofs[cfg_ch] <= cfg_wdata[PH_W-1:0];
    end
  end
`else
  assign phase = acc[gidx][FCW_W-1:PH_LSB];
`endif

  // Grant uses the pre-write enable vector; a channel being enabled is not
  // grantable this cycle, so its acc clear never collides with an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        fcw[i] <= '0;
        acc[i] <= '0;
      end
      en         <= '0;
      last       <= CH_W'(NCH - 1);
      core_vld   <= 1'b0;
      core_phase <= '0;
    end else begin
      core_vld <= gvld;
      if (gvld) begin
        core_phase <= phase;
        last       <= gidx;
      end
      for (int i = 0; i < NCH; i++) begin
        if (gnt[i]) acc[i] <= acc[i] + fcw[i];
      end
      if (cfg_we && ch_ok) begin
        case (cfg_sel)
          CFG_FCW: fcw[cfg_ch] <= cfg_wdata;
          CFG_EN: begin
            en[cfg_ch] <= cfg_wdata[0];
            if (cfg_wdata[0] && !en[cfg_ch]) acc[cfg_ch] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Tag line: stage 0 samples the issue, stage LAT-1 drives res_vld/res_ch.
  generate
    if (LAT == 1) begin : g_cap_direct
      assign cap = core_vld;
    end else begin : g_cap_pipe
      assign cap = tv[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
      for (int j = 0; j < LAT; j++) tc[j] <= '0;
      res_sin <= '0;
      res_cos <= '0;
    end else begin
      tv[0] <= core_vld;
      tc[0] <= last;
      for (int j = 1; j < LAT; j++) begin
        tv[j] <= tv[j-1];
        tc[j] <= tc[j-1];
      end
      if (cap) begin
        res_sin <= core_sin;
        res_cos <= core_cos;
      end
    end
  end

  assign res_vld = tv[LAT-1];
  assign res_ch  = tc[LAT-1];

endmodule

`default_nettype wire
